// File: rtl/cond_status_unit.sv
// Condition evaluator and {N,Z,C,V} status register between ID and EXE; optional COND_FLAG_BYPASS_EN.
// Latency: 1 cycle ID accept -> ex_* registered; status write-back visible in sr after the write edge.
// Backpressure: id_ready combinational, drops on flush, pending flag writers, or writer-count saturation.
module cond_status_unit #(
  parameter int MAX_OUT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       status_we,
  input  logic [3:0] status_in,
  input  logic       flush,
  output logic [3:0] sr,
  output logic       ex_valid,
  output logic       ex_exec,
  output logic       ex_s,
  output logic [2:0] outstanding
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond_e'(cond))
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c & !z;
      COND_LS: res = !c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic       uncond;
  logic       bypass;
  logic [3:0] ef;
  logic       cond_wait;
  logic       s_full;
  logic       pass;
  logic       accept;
  logic       cnt_inc;
  logic       cnt_dec;
  logic [2:0] outstanding_nxt;

  assign uncond = (id_cond == COND_AL) | (id_cond == COND_NV);

`ifdef COND_FLAG_BYPASS_EN
  // The single pending writer is retiring now, so its flags can be used directly.
  assign bypass = status_we & (outstanding == 3'd1);
`else
  assign bypass = 1'b0;
`endif

  assign ef        = bypass ? status_in : sr;
  assign cond_wait = !uncond & (outstanding != 3'd0) & !bypass;
  assign s_full    = id_s & (outstanding == MAX_CNT);
  assign id_ready  = !flush & !cond_wait & !s_full;
  assign pass      = cond_pass(id_cond, ef);
  assign accept    = id_valid & id_ready;
  assign cnt_inc   = accept & id_s & pass;
  assign cnt_dec   = status_we & (outstanding != 3'd0);

  always_comb begin
    outstanding_nxt = outstanding;
    if (flush) begin
      outstanding_nxt = 3'd0;
    end else if (cnt_inc & !cnt_dec) begin
      outstanding_nxt = outstanding + 3'd1;
    end else if (cnt_dec & !cnt_inc) begin
      outstanding_nxt = outstanding - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= 4'b0000;
      outstanding <= 3'd0;
    end else begin
      if (status_we) begin
        sr <= status_in;
      end
      outstanding <= outstanding_nxt;
    end
  end

  // accept is already low under flush, so a flush naturally produces a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_exec  <= 1'b0;
      ex_s     <= 1'b0;
    end else begin
      ex_valid <= accept;
      ex_exec  <= accept & pass;
      ex_s     <= accept & pass & id_s;
    end
  end

endmodule
